div_unit: RTL

- Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
- Responds to the decoder's isdiv/signeddiv request and holds the pipeline with a stall until the result is ready.
- Delivers the quotient to LO and the remainder to HI through a one-cycle valid pulse, alongside the hiwrite/lowrite path.

---
 rtl/div_unit_if.sv | 52 +++++
 rtl/div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Groups the execute-stage divide request and the divide response into one
// bundle. The pipeline side uses the master modport and the divider uses the
// slave modport.
//
// Signals:
//   start       request from the decoder (isdiv & E-stage valid)
//   signed_div  1 = DIV (signed), 0 = DIVU
//   a, b        dividend (rs) and divisor (rt)
//   annul       exception/flush; aborts any divide in progress
//   stall_div   pipeline hold request from the divider
//   valid       one-cycle pulse: hi/lo hold a new result
//   hi, lo      remainder and quotient
// -----------------------------------------------------------------------------
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             stall_div;
    logic             valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start,
        output signed_div,
        output a,
        output b,
        output annul,
        input  stall_div,
        input  valid,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  signed_div,
        input  a,
        input  b,
        input  annul,
        output stall_div,
        output valid,
        output hi,
        output lo
    );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Operands are reduced to magnitudes on capture, divided for WIDTH iterations
// (one quotient bit per cycle), and the signs are restored when the result is
// written into hi (remainder) and lo (quotient). The pipeline is held through
// stall_div until the result is ready. The result is announced by a one-cycle
// valid pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   div_unit_if.slave: start/signed_div/a/b/annul in,
//                            stall_div/valid/hi/lo out
//
// Timing (start in cycle 0):
//   normal divide : BUSY cycles 1..WIDTH, valid in cycle WIDTH+1
//   divide by zero: valid in cycle 1 (lo = all ones, hi = dividend)
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude of v when s is set, otherwise v unchanged.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                               input logic             s);
        logic [WIDTH-1:0] res;
        if (s && v[WIDTH-1]) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Conditional two's-complement negation used for the sign fix-up.
    function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v,
                                                  input logic             s);
        logic [WIDTH-1:0] res;
        if (s) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic             w_stall;
    logic             w_valid;
    logic             w_capture;
    logic             w_b_zero;
    logic             w_last;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;
    logic             r_qsign;
    logic             r_rsign;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi_prev;
    logic [WIDTH-1:0] r_lo_prev;

    logic [WIDTH:0]   w_rem_sh;
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_capture = bus.start & ~bus.annul;
    assign w_b_zero  = (bus.b == {WIDTH{1'b0}});
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // One restoring step. The shifted remainder is WIDTH+1 bits wide. Its top
    // bit plus the borrow of the low WIDTH-bit subtract decide rem_sh >= |b|.
    // When the top bit is set the true difference still fits in WIDTH bits,
    // so w_diff is exact in both cases.
    assign w_rem_sh              = {r_rem, r_quo[WIDTH-1]};
    assign {w_borrow, w_diff}    = {1'b0, w_rem_sh[WIDTH-1:0]} - {1'b0, r_divisor};
    assign w_ge                  = w_rem_sh[WIDTH] | ~w_borrow;
    assign w_rem_next            = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_quo_next            = {r_quo[WIDTH-2:0], w_ge};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the stall/valid outputs. annul forces IDLE and
    // drops both outputs in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_capture;
                if (w_capture) begin
                    if (w_b_zero) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_BUSY;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.annul) begin
                    w_stall      = 1'b0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (w_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                w_valid      = ~bus.annul;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, the iteration step, and hi/lo commit with
    // sign fix-up. The previous hi/lo are kept aside so an annul in the DONE
    // cycle can put them back. That makes the aborted result invisible once
    // DONE has passed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= {WIDTH{1'b0}};
            r_quo     <= {WIDTH{1'b0}};
            r_divisor <= {WIDTH{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
            r_hi_prev <= {WIDTH{1'b0}};
            r_lo_prev <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_divisor <= f_mag(bus.b, bus.signed_div);
                        r_quo     <= f_mag(bus.a, bus.signed_div);
                        r_rem     <= {WIDTH{1'b0}};
                        r_cnt     <= {CNT_W{1'b0}};
                        r_qsign   <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_rsign   <= bus.signed_div & bus.a[WIDTH-1];
                        if (w_b_zero) begin
                            // Divide by zero skips BUSY: quotient saturates to
                            // all ones and the dividend passes through untouched.
                            r_hi_prev <= r_hi;
                            r_lo_prev <= r_lo;
                            r_hi      <= bus.a;
                            r_lo      <= {WIDTH{1'b1}};
                        end
                    end
                end
                ST_BUSY: begin
                    if (!bus.annul) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (w_last) begin
                            r_hi_prev <= r_hi;
                            r_lo_prev <= r_lo;
                            r_hi      <= f_neg_if(w_rem_next, r_rsign);
                            r_lo      <= f_neg_if(w_quo_next, r_qsign);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.annul) begin
                        r_hi <= r_hi_prev;
                        r_lo <= r_lo_prev;
                    end
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.stall_div = w_stall;
    assign bus.valid     = w_valid;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule
